// File: rtl/prog_arb_pkg.sv
// Shared types for the program-memory arbiter: FSM states and requester ids.
package prog_arb_pkg;
  typedef enum logic [2:0] {
    LDR_RST = 3'd0,
    LDR_REQ = 3'd1,
    LOAD    = 3'd2,
    RUN     = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

  localparam int DATA_W = 8;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req[0]=CPU, req[1]=DBG. On contention the port
// that did not win last gets the grant; the pointer follows every grant.
module rr_arb2
  import prog_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);
  req_id_t r_last;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last == REQ_CPU) ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)         r_last <= REQ_CPU;
    else if (o_gnt[1]) r_last <= REQ_DBG;
    else if (o_gnt[0]) r_last <= REQ_CPU;
  end
endmodule

// File: rtl/prog_mem_arbiter.sv
// Program RAM owner: sequences the loader after reset/reload, then shares the
// RAM between CPU fetch and (with PROG_ARB_DBG_PORT_EN) a host debug read port.
module prog_mem_arbiter
  import prog_arb_pkg::*;
#(
  parameter int PROG_ADDR_WIDTH = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_reload_req,
  output logic                       o_ldr_resetn,
  output logic                       o_load_req,
  input  logic                       i_ldr_we,
  input  logic [PROG_ADDR_WIDTH-1:0] i_ldr_addr,
  input  logic [DATA_W-1:0]          i_ldr_wdata,
  input  logic                       i_ldr_loaded,
  output logic                       o_cpu_run,
  input  logic                       i_cpu_req,
  input  logic [PROG_ADDR_WIDTH-1:0] i_cpu_addr,
  output logic                       o_cpu_gnt,
  output logic                       o_cpu_rvalid,
  output logic [DATA_W-1:0]          o_cpu_rdata,
`ifdef PROG_ARB_DBG_PORT_EN
  input  logic                       i_dbg_req,
  input  logic [PROG_ADDR_WIDTH-1:0] i_dbg_addr,
  output logic                       o_dbg_gnt,
  output logic                       o_dbg_rvalid,
  output logic [DATA_W-1:0]          o_dbg_rdata,
`endif
  output logic                       o_mem_we,
  output logic [PROG_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_W-1:0]          o_mem_wdata,
  input  logic [DATA_W-1:0]          i_mem_rdata,
  output logic                       o_busy
);
  state_t r_state;
  state_t w_next;
  logic   r_cpu_run;
  logic   r_cpu_rvalid;
  logic   w_run;
  logic   w_cpu_gnt;

  assign w_run = (r_state == RUN);

  always_comb begin
    w_next = r_state;
    case (r_state)
      LDR_RST: w_next = LDR_REQ;
      LDR_REQ: w_next = LOAD;
      LOAD:    if (i_ldr_loaded) w_next = RUN;
      RUN:     if (i_reload_req) w_next = DRAIN;
      DRAIN:   w_next = LDR_RST;
      default: w_next = LDR_RST;
    endcase
  end

`ifdef PROG_ARB_DBG_PORT_EN
  logic [1:0] w_gnt;
  logic       w_dbg_gnt;
  logic       r_dbg_rvalid;

  rr_arb2 u_rr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req ({i_dbg_req & w_run, i_cpu_req & w_run}),
    .o_gnt (w_gnt)
  );
  assign w_cpu_gnt = w_gnt[0];
  assign w_dbg_gnt = w_gnt[1];
`else
  assign w_cpu_gnt = i_cpu_req & w_run;
`endif

  // Leaving RUN on reload drops cpu_run in the same edge that enters DRAIN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= LDR_RST;
      r_cpu_run    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
`ifdef PROG_ARB_DBG_PORT_EN
      r_dbg_rvalid <= 1'b0;
`endif
    end else begin
      r_state      <= w_next;
      r_cpu_run    <= w_run & ~i_reload_req;
      r_cpu_rvalid <= w_cpu_gnt;
`ifdef PROG_ARB_DBG_PORT_EN
      r_dbg_rvalid <= w_dbg_gnt;
`endif
    end
  end

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (r_state == LOAD) begin
      o_mem_we    = i_ldr_we;
      o_mem_addr  = i_ldr_addr;
      o_mem_wdata = i_ldr_wdata;
    end else if (w_cpu_gnt) begin
      o_mem_addr = i_cpu_addr;
    end
`ifdef PROG_ARB_DBG_PORT_EN
    else if (w_dbg_gnt) begin
      o_mem_addr = i_dbg_addr;
    end
`endif
  end

  assign o_ldr_resetn = (r_state != LDR_RST);
  assign o_load_req   = (r_state == LDR_REQ);
  assign o_busy       = ~w_run;
  assign o_cpu_run    = r_cpu_run;
  assign o_cpu_gnt    = w_cpu_gnt;
  assign o_cpu_rvalid = r_cpu_rvalid;
  assign o_cpu_rdata  = i_mem_rdata;
`ifdef PROG_ARB_DBG_PORT_EN
  assign o_dbg_gnt    = w_dbg_gnt;
  assign o_dbg_rvalid = r_dbg_rvalid;
  assign o_dbg_rdata  = i_mem_rdata;
`endif
endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Bench for prog_mem_arbiter: loader/RAM models, vector table, directed
// reload/reset sequences and a randomized fetch phase against a grant model.
module tb_prog_mem_arbiter;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reload_req = 1'b0;
  logic          ldr_resetn, load_req;
  logic          ldr_we = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [7:0]    ldr_wdata = '0;
  logic          ldr_loaded = 1'b0;
  logic          cpu_run;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [7:0]    cpu_rdata;
`ifdef PROG_ARB_DBG_PORT_EN
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic [7:0]    dbg_rdata;
`endif
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  prog_mem_arbiter #(.PROG_ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_reload_req(reload_req),
    .o_ldr_resetn(ldr_resetn), .o_load_req(load_req),
    .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr), .i_ldr_wdata(ldr_wdata),
    .i_ldr_loaded(ldr_loaded), .o_cpu_run(cpu_run),
    .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .o_cpu_gnt(cpu_gnt),
    .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
`ifdef PROG_ARB_DBG_PORT_EN
    .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr), .o_dbg_gnt(dbg_gnt),
    .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
`endif
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  // Single-port RAM with 1-cycle read latency; exp_mem is what the bench believes it holds.
  logic [7:0] ram     [0:4095] = '{default: 8'h00};
  logic [7:0] exp_mem [0:4095] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int total = 0;
  int bad   = 0;
  logic          p_c = 1'b0, p_d = 1'b0;
  logic [AW-1:0] p_a = '0;
  bit            m_last_dbg;

  typedef struct {
    logic          c;
    logic [AW-1:0] ca;
    logic          d;
    logic [AW-1:0] da;
    logic          ec;
    logic          ed;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    #4;
  endtask

  // Entry: sampled point of an LDR_RST cycle. Exit: just after an edge, in RUN.
  // abort_at >= 0 asserts rst instead of writing that byte and returns in LDR_RST.
  task automatic do_load(input int n, input logic [7:0] base, input int abort_at);
    chk("ldr_resetn_low", ldr_resetn, 1'b0);
    chk("load_req_idle", load_req, 1'b0);
    step();
    samp();
    chk("ldr_resetn_high", ldr_resetn, 1'b1);
    chk("load_req_pulse", load_req, 1'b1);
    chk("busy_ldr_req", busy, 1'b1);
    step();
    cpu_req = 1'b1; cpu_addr = 12'h001; reload_req = 1'b1;
    samp();
    chk("load_req_end", load_req, 1'b0);
    chk("load_no_gnt", cpu_gnt, 1'b0);
    step();
    cpu_req = 1'b0; reload_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        cpu_req = 1'b1;
        samp();
        chk("abort_no_gnt", cpu_gnt, 1'b0);
        chk("abort_busy", busy, 1'b1);
        cpu_req = 1'b0;
        return;
      end
      ldr_we = 1'b1; ldr_addr = AW'(i); ldr_wdata = base + 8'(i);
      samp();
      chk("load_mem_we", mem_we, 1'b1);
      chk("load_mem_addr", mem_addr, AW'(i));
      chk("load_mem_wdata", mem_wdata, base + 8'(i));
      exp_mem[i] = base + 8'(i);
      step();
    end
    ldr_we = 1'b0; ldr_loaded = 1'b1;
    samp();
    chk("loaded_busy", busy, 1'b1);
    chk("loaded_run0", cpu_run, 1'b0);
    step();
    ldr_loaded = 1'b0;
    samp();
    chk("run_entry_busy", busy, 1'b0);
    chk("run_entry_cpu_run", cpu_run, 1'b0);
    step();
    samp();
    chk("cpu_run_rise", cpu_run, 1'b1);
    step();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cpu_req = 1'b1; cpu_addr = a;
    samp();
    chk("rd_gnt", cpu_gnt, 1'b1);
    chk("rd_mem_addr", mem_addr, a);
    chk("rd_mem_we", mem_we, 1'b0);
    step();
    cpu_req = 1'b0;
    samp();
    chk("rd_rvalid", cpu_rvalid, 1'b1);
    chk("rd_rdata", cpu_rdata, exp_mem[a]);
    step();
  endtask

  // One RUN cycle: drive requests, check grants and the previous cycle's read return.
  task automatic apply(input logic c, input logic [AW-1:0] ca, input logic d,
                       input logic [AW-1:0] da, input logic ec, input logic ed);
    cpu_req = c; cpu_addr = ca;
`ifdef PROG_ARB_DBG_PORT_EN
    dbg_req = d; dbg_addr = da;
`endif
    samp();
    chk("cpu_gnt", cpu_gnt, ec);
    chk("cpu_rvalid", cpu_rvalid, p_c);
    if (p_c) chk("cpu_rdata", cpu_rdata, exp_mem[p_a]);
`ifdef PROG_ARB_DBG_PORT_EN
    chk("dbg_gnt", dbg_gnt, ed);
    chk("dbg_rvalid", dbg_rvalid, p_d);
    if (p_d) chk("dbg_rdata", dbg_rdata, exp_mem[p_a]);
`endif
    if (ec || ed) chk("mem_addr", mem_addr, ec ? ca : da);
    p_c = ec; p_d = ed; p_a = ec ? ca : da;
    step();
  endtask

  initial begin
    // {cpu_req, cpu_addr, dbg_req, dbg_addr, exp cpu_gnt, exp dbg_gnt}; DBG won last.
    tbl[0] = '{1'b1, 12'h000, 1'b1, 12'h001, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 12'h002, 1'b1, 12'h003, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 12'h004, 1'b1, 12'h000, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 12'h001, 1'b1, 12'h002, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 12'h000, 1'b1, 12'h003, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 12'h004, 1'b1, 12'h000, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 12'h002, 1'b0, 12'h000, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 12'h003, 1'b1, 12'h001, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0};

    // Test 1: reset state and initial load
    repeat (3) step();
    rst = 1'b0;
    samp();
    chk("rst_cpu_run", cpu_run, 1'b0);
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 12'h000);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_busy", busy, 1'b1);
    do_load(5, 8'hA0, -1);
    for (int i = 0; i < 5; i++) chk("ram_after_load", ram[i], 8'hA0 + 8'(i));

    // Test 2: single fetches
    rd(12'h003);
    for (int i = 0; i < 5; i++) rd(AW'(i));

    // Test 3: contention table (lone DBG read first so DBG is last winner)
`ifdef PROG_ARB_DBG_PORT_EN
    apply(1'b0, 12'h000, 1'b1, 12'h001, 1'b0, 1'b1);
`endif
    for (int i = 0; i < 10; i++) begin
`ifdef PROG_ARB_DBG_PORT_EN
      apply(tbl[i].c, tbl[i].ca, tbl[i].d, tbl[i].da, tbl[i].ec, tbl[i].ed);
`else
      apply(tbl[i].c, tbl[i].ca, 1'b0, 12'h000, tbl[i].c, 1'b0);
`endif
    end

    // Test 6: back-to-back CPU fetch gets a grant every cycle
    for (int i = 0; i < 8; i++) apply(1'b1, AW'(i % 5), 1'b0, 12'h000, 1'b1, 1'b0);
    apply(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);

    // Test 4: reload with a fetch in the same cycle
    cpu_req = 1'b1; cpu_addr = 12'h002; reload_req = 1'b1;
    samp();
    chk("reload_gnt", cpu_gnt, 1'b1);
    chk("reload_cpu_run", cpu_run, 1'b1);
    step();
    reload_req = 1'b0;
    samp();
    chk("drain_busy", busy, 1'b1);
    chk("drain_cpu_run", cpu_run, 1'b0);
    chk("drain_no_gnt", cpu_gnt, 1'b0);
    chk("drain_rvalid", cpu_rvalid, 1'b1);
    chk("drain_rdata", cpu_rdata, 8'hA2);
    step();
    cpu_req = 1'b0;
    samp();
    chk("post_drain_rvalid", cpu_rvalid, 1'b0);
    do_load(5, 8'h50, -1);
    for (int i = 0; i < 5; i++) rd(AW'(i));

    // Test 5: rst during RUN drops the in-flight read; rst mid-LOAD restarts
    cpu_req = 1'b1; cpu_addr = 12'h001; rst = 1'b1;
    samp();
    chk("rst_run_gnt", cpu_gnt, 1'b1);
    step();
    rst = 1'b0; cpu_req = 1'b0;
    samp();
    chk("rst_drop_rvalid", cpu_rvalid, 1'b0);
    chk("rst_drop_run", cpu_run, 1'b0);
    do_load(5, 8'h70, 2);
    do_load(5, 8'h70, -1);
    for (int i = 0; i < 5; i++) rd(AW'(i));

    // Randomized fetch traffic; last grant was CPU
    m_last_dbg = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic c, d, ec, ed;
      logic [AW-1:0] ca, da;
      c  = 1'($urandom_range(0, 1));
      ca = AW'($urandom_range(0, 4));
      da = AW'($urandom_range(0, 4));
`ifdef PROG_ARB_DBG_PORT_EN
      d = 1'($urandom_range(0, 1));
      if (c && d) begin
        ed = !m_last_dbg;
        ec = m_last_dbg;
      end else begin
        ec = c;
        ed = d;
      end
      if (ed) m_last_dbg = 1'b1;
      else if (ec) m_last_dbg = 1'b0;
`else
      d = 1'b0; ec = c; ed = 1'b0;
`endif
      apply(c, ca, d, da, ec, ed);
    end
    apply(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
